// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the buffer-RAM port arbiter.
// State encoding, legal read latencies and tag-width math.
package bram_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned LAT_LOW  = 1;
    localparam int unsigned LAT_HIGH = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit lat_legal(input int unsigned lat);
        return (lat == LAT_LOW) || (lat == LAT_HIGH);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bundle of the buffer-RAM port arbiter.
// master = engines issuing beats, slave = the arbiter.
interface bram_port_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16
) ();

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wr;
    logic [N-1:0]    req_last;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    modport master (
        output req_valid,
        output req_wr,
        output req_last,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_last,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Shared by every controller that arbitrates a single resource.
module round_robin_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW:0]   j;
    logic [IW-1:0] jn;

    // Scan from the pointer, wrapping modulo N, stop at the first hit
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        jn    = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr_i} + (IW+1)'(k);
            if (j >= (IW+1)'(N)) begin
                j = j - (IW+1)'(N);
            end
            jn = j[IW-1:0];
            if (en_i && !found && req_i[jn]) begin
                found     = 1'b1;
                gnt_o[jn] = 1'b1;
                idx_o     = jn;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one no-change BRAM port between several engines with
// round-robin grants, burst locking and tagged read responses.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned C_NUM_REQ    = 4,
    parameter int unsigned C_ADDR_WIDTH = 10,
    parameter int unsigned C_DATA_WIDTH = 16,
    parameter int unsigned C_RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bram_port_arbiter_if.slave      bus,
    output logic [C_ADDR_WIDTH-1:0] ram_addr,
    output logic                    ram_wren,
    output logic [C_DATA_WIDTH-1:0] ram_din,
    output logic                    ram_rden,
    input  logic [C_DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned N     = C_NUM_REQ;
    localparam int unsigned AW    = C_ADDR_WIDTH;
    localparam int unsigned DW    = C_DATA_WIDTH;
    localparam int unsigned IW    = clog2(N);
    localparam int unsigned DEPTH = C_RD_LATENCY + 1;

    if (!lat_legal(C_RD_LATENCY)) begin : g_bad_lat
        $error("bram_port_arbiter: C_RD_LATENCY must be 1 or 3");
    end

    if (N < 2 || N > 8) begin : g_bad_n
        $error("bram_port_arbiter: C_NUM_REQ must be 2..8");
    end

    function automatic logic [IW-1:0] nxt_ptr(input logic [IW-1:0] p);
        return (p == IW'(N-1)) ? '0 : p + 1'b1;
    endfunction

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;

    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic [N-1:0]  ready;
    logic [IW-1:0] win;
    logic          acc;
    logic          acc_wr;
    logic          acc_last;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    logic [AW-1:0] ram_addr_q;
    logic          ram_wren_q;
    logic [DW-1:0] ram_din_q;
    logic          ram_rden_q;

    logic [DEPTH-1:0] tag_v_q;
    logic [IW-1:0]    tag_id_q [DEPTH];
    logic [N-1:0]     rsp_valid;

    round_robin_arbiter #(
        .N (N)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (rst_n && (state_q == ARB)),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Grant vector, winner and the beat it carries
    always_comb begin
        ready = '0;
        unique case (state_q)
            ARB:     ready = arb_gnt;
            BURST:   ready[owner_q] = bus.req_valid[owner_q];
            default: ready = '0;
        endcase
        if (!rst_n) begin
            ready = '0;
        end
        win      = (state_q == BURST) ? owner_q : arb_idx;
        acc      = |(ready & bus.req_valid);
        acc_wr   = bus.req_wr[win];
        acc_last = bus.req_last[win];
        win_addr = bus.req_addr[int'(win)*AW +: AW];
        win_data = bus.req_wdata[int'(win)*DW +: DW];
    end

    // Lock / release decisions on each accepted beat
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (acc) begin
            if (acc_last) begin
                state_d = ARB;
                ptr_d   = nxt_ptr(win);
            end else begin
                state_d = BURST;
                owner_d = win;
            end
        end
    end

    // Arbitration FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Registered RAM port; rden stays high so latency is fixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
            ram_wren_q <= 1'b0;
            ram_din_q  <= '0;
            ram_rden_q <= 1'b0;
        end else begin
            ram_rden_q <= 1'b1;
            ram_wren_q <= acc && acc_wr;
            if (acc) begin
                ram_addr_q <= win_addr;
                ram_din_q  <= win_data;
            end
        end
    end

    // Read tags travel alongside the RAM pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_v_q     <= {tag_v_q[DEPTH-2:0], acc && !acc_wr};
            tag_id_q[0] <= win;
            for (int i = 1; i < DEPTH; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Decode the oldest tag into a one-hot response strobe
    always_comb begin
        rsp_valid = '0;
        if (tag_v_q[DEPTH-1]) begin
            rsp_valid[tag_id_q[DEPTH-1]] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = ram_dout;

    assign ram_addr = ram_addr_q;
    assign ram_wren = ram_wren_q;
    assign ram_din  = ram_din_q;
    assign ram_rden = ram_rden_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 3) share
// the same requester stimulus, each with its own BRAM model.
module tb_bram_port_arbiter;

    logic clk;
    logic rst_n;

    logic [3:0]  v;
    logic [3:0]  wr;
    logic [3:0]  last;
    logic [39:0] addr;
    logic [63:0] wd;

    int n_tot;
    int n_bad;

    bram_port_arbiter_if #(.N(4), .AW(10), .DW(16)) if1 ();
    bram_port_arbiter_if #(.N(4), .AW(10), .DW(16)) if3 ();

    assign if1.req_valid = v;
    assign if1.req_wr    = wr;
    assign if1.req_last  = last;
    assign if1.req_addr  = addr;
    assign if1.req_wdata = wd;
    assign if3.req_valid = v;
    assign if3.req_wr    = wr;
    assign if3.req_last  = last;
    assign if3.req_addr  = addr;
    assign if3.req_wdata = wd;

    logic [9:0]  ram_addr1, ram_addr3;
    logic        ram_wren1, ram_wren3;
    logic [15:0] ram_din1, ram_din3;
    logic        ram_rden1, ram_rden3;
    logic [15:0] ram_dout1, ram_dout3;

    bram_port_arbiter #(
        .C_NUM_REQ(4), .C_ADDR_WIDTH(10),
        .C_DATA_WIDTH(16), .C_RD_LATENCY(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .ram_addr(ram_addr1), .ram_wren(ram_wren1),
        .ram_din(ram_din1), .ram_rden(ram_rden1),
        .ram_dout(ram_dout1)
    );

    bram_port_arbiter #(
        .C_NUM_REQ(4), .C_ADDR_WIDTH(10),
        .C_DATA_WIDTH(16), .C_RD_LATENCY(3)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3),
        .ram_addr(ram_addr3), .ram_wren(ram_wren3),
        .ram_din(ram_din3), .ram_rden(ram_rden3),
        .ram_dout(ram_dout3)
    );

    // No-change BRAM models with a bench-side preload port
    logic [15:0] mem1 [1024];
    logic [15:0] mem3 [1024];
    logic [15:0] d1, d3a, d3b, d3c;
    logic        pl_we;
    logic [9:0]  pl_a;
    logic [15:0] pl_d;

    always @(posedge clk) begin
        if (pl_we) mem1[pl_a] <= pl_d;
        else if (ram_rden1) begin
            if (ram_wren1) mem1[ram_addr1] <= ram_din1;
            else d1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        if (pl_we) mem3[pl_a] <= pl_d;
        else if (ram_rden3) begin
            if (ram_wren3) mem3[ram_addr3] <= ram_din3;
            else d3a <= mem3[ram_addr3];
        end
        d3b <= d3a;
        d3c <= d3b;
    end

    assign ram_dout1 = d1;
    assign ram_dout3 = d3c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int r, input logic w, input logic l,
                        input logic [9:0] a, input logic [15:0] d);
        v[r] = 1'b1;
        wr[r] = w;
        last[r] = l;
        addr[r*10 +: 10] = a;
        wd[r*16 +: 16] = d;
    endtask

    task automatic chk_rsp(input string tag, input logic [3:0] e1,
                           input logic [15:0] ed1, input logic [3:0] e3,
                           input logic [15:0] ed3);
        chk({tag, "_v1"}, 32'(if1.rsp_valid), 32'(e1));
        if (e1 != 4'b0) chk({tag, "_d1"}, 32'(if1.rsp_data), 32'(ed1));
        chk({tag, "_v3"}, 32'(if3.rsp_valid), 32'(e3));
        if (e3 != 4'b0) chk({tag, "_d3"}, 32'(if3.rsp_data), 32'(ed3));
    endtask

    logic [9:0]  pl_at [6] = '{10'h010, 10'h020, 10'h005,
                               10'h006, 10'h007, 10'h008};
    logic [15:0] pl_dt [6] = '{16'hAAAA, 16'hBBBB, 16'h5000,
                               16'h5001, 16'h5002, 16'h5003};

    logic [3:0] t3_v  [7] = '{4'b0101, 4'b0101, 4'b0001, 4'b0101,
                              4'b0101, 4'b0001, 4'b0000};
    logic       t3_l  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [9:0] t3_a  [7] = '{10'h100, 10'h101, 10'h101, 10'h102,
                              10'h103, 10'h103, 10'h103};
    logic [3:0] t3_r  [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100,
                              4'b0100, 4'b0001, 4'b0000};
    logic       t3_w  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [9:0] t3_ea [7] = '{10'h020, 10'h100, 10'h101, 10'h101,
                              10'h102, 10'h103, 10'h010};

    initial begin
        logic [3:0]  e1, e3, er;
        logic [15:0] ed1, ed3;
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        v = '0; wr = '0; last = '0; addr = '0; wd = '0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;

        // Reset: preload both RAMs, grants must stay low
        for (int i = 0; i < 6; i++) begin
            tick();
            pl_we = 1'b1;
            pl_a  = pl_at[i];
            pl_d  = pl_dt[i];
        end
        tick();
        pl_we = 1'b0;
        v = 4'b0011;
        #3;
        chk("rst_ready1", 32'(if1.req_ready), 32'h0);
        chk("rst_ready3", 32'(if3.req_ready), 32'h0);
        chk("rst_rden1", 32'(ram_rden1), 32'h0);
        chk("rst_addr1", 32'(ram_addr1), 32'h0);
        chk("rst_rsp1", 32'(if1.rsp_valid), 32'h0);
        v = '0;
        tick();
        rst_n = 1'b1;
        tick();
        #3;
        chk("rel_rden1", 32'(ram_rden1), 32'h1);
        chk("rel_rden3", 32'(ram_rden3), 32'h1);
        chk("rel_ready1", 32'(if1.req_ready), 32'h0);
        chk("rel_wren1", 32'(ram_wren1), 32'h0);
        chk("rel_din1", 32'(ram_din1), 32'h0);
        chk("rel_rsp3", 32'(if3.rsp_valid), 32'h0);

        // Two simultaneous single-beat reads
        tick();
        v = '0; wr = '0; last = '0;
        beat(0, 1'b0, 1'b1, 10'h010, 16'h0);
        beat(1, 1'b0, 1'b1, 10'h020, 16'h0);
        #3;
        chk("t2_rdy0_1", 32'(if1.req_ready), 32'h1);
        chk("t2_rdy0_3", 32'(if3.req_ready), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            v = (k == 1) ? 4'b0010 : 4'b0000;
            #3;
            if (k == 1) begin
                chk("t2_rdy1", 32'(if1.req_ready), 32'h2);
                chk("t2_addr_a", 32'(ram_addr1), 32'h010);
            end
            if (k == 2) chk("t2_addr_b", 32'(ram_addr1), 32'h020);
            e1  = (k == 2) ? 4'b0001 : (k == 3) ? 4'b0010 : 4'b0000;
            ed1 = (k == 2) ? 16'hAAAA : 16'hBBBB;
            e3  = (k == 4) ? 4'b0001 : (k == 5) ? 4'b0010 : 4'b0000;
            ed3 = (k == 4) ? 16'hAAAA : 16'hBBBB;
            chk_rsp("t2", e1, ed1, e3, ed3);
        end

        // req2 write burst with an idle beat, req0 waiting
        for (int j = 0; j < 7; j++) begin
            tick();
            v = t3_v[j];
            wr = 4'b0100;
            last = {1'b0, t3_l[j], 1'b0, 1'b1};
            addr[0 +: 10] = 10'h010;
            addr[20 +: 10] = t3_a[j];
            wd[32 +: 16] = 16'hC000 + 16'(t3_a[j][1:0]);
            #3;
            chk("t3_rdy1", 32'(if1.req_ready), 32'(t3_r[j]));
            chk("t3_rdy3", 32'(if3.req_ready), 32'(t3_r[j]));
            chk("t3_wren", 32'(ram_wren1), 32'(t3_w[j]));
            chk("t3_addr", 32'(ram_addr1), 32'(t3_ea[j]));
            if (t3_w[j]) begin
                chk("t3_din", 32'(ram_din1),
                    32'(16'hC000 + 16'(t3_ea[j][1:0])));
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_mem1", 32'(mem1[256+i]), 32'(16'hC000 + 16'(i)));
            chk("t3_mem3", 32'(mem3[256+i]), 32'(16'hC000 + 16'(i)));
        end
        v = '0;
        repeat (5) tick();

        // req3 back-to-back read burst of 0x005..0x008
        for (int k = 0; k < 9; k++) begin
            tick();
            v = '0; wr = '0; last = '0;
            if (k < 4) begin
                beat(3, 1'b0, (k == 3), 10'(5 + k), 16'h0);
            end
            #3;
            er = (k < 4) ? 4'b1000 : 4'b0000;
            chk("t4_rdy1", 32'(if1.req_ready), 32'(er));
            chk("t4_rdy3", 32'(if3.req_ready), 32'(er));
            e1  = (k >= 2 && k <= 5) ? 4'b1000 : 4'b0000;
            ed1 = 16'h5000 + 16'(k - 2);
            e3  = (k >= 4 && k <= 7) ? 4'b1000 : 4'b0000;
            ed3 = 16'h5000 + 16'(k - 4);
            chk_rsp("t4", e1, ed1, e3, ed3);
        end

        // Write then read the same address on consecutive beats
        for (int k = 0; k < 8; k++) begin
            tick();
            v = '0; wr = '0; last = '0;
            if (k == 0) beat(1, 1'b1, 1'b1, 10'h3FF, 16'h1234);
            if (k == 1) beat(1, 1'b0, 1'b1, 10'h3FF, 16'h0);
            #3;
            er = (k < 2) ? 4'b0010 : 4'b0000;
            chk("t5_rdy1", 32'(if1.req_ready), 32'(er));
            e1 = (k == 3) ? 4'b0010 : 4'b0000;
            e3 = (k == 5) ? 4'b0010 : 4'b0000;
            chk_rsp("t5", e1, 16'h1234, e3, 16'h1234);
        end

        // Reset in the middle of a locked read burst
        for (int k = 0; k < 2; k++) begin
            tick();
            v = '0; wr = '0; last = '0;
            beat(0, 1'b0, 1'b0, (k == 0) ? 10'h010 : 10'h020, 16'h0);
            #3;
            chk("t6_rdy1", 32'(if1.req_ready), 32'h1);
            chk("t6_rdy3", 32'(if3.req_ready), 32'h1);
        end
        tick();
        rst_n = 1'b0;
        #3;
        chk("t6_rst_rdy1", 32'(if1.req_ready), 32'h0);
        chk("t6_rst_rden1", 32'(ram_rden1), 32'h0);
        chk_rsp("t6_rst", 4'b0, 16'h0, 4'b0, 16'h0);
        tick();
        #3;
        chk_rsp("t6_rst2", 4'b0, 16'h0, 4'b0, 16'h0);
        tick();
        rst_n = 1'b1;
        v = '0; wr = '0; last = '0;
        beat(1, 1'b1, 1'b1, 10'h200, 16'h7777);
        #3;
        chk("t6_rel_rdy1", 32'(if1.req_ready), 32'h2);
        chk("t6_rel_rdy3", 32'(if3.req_ready), 32'h2);
        for (int k = 0; k < 6; k++) begin
            tick();
            v = '0;
            #3;
            chk_rsp("t6_post", 4'b0, 16'h0, 4'b0, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the true-dual-port no-change BRAM between C_NUM_REQ requesters.
- Uses round-robin arbitration with burst locking.
- Drives the RAM port's addr/wren/din/rden from registers.
- Tracks read latency for either RAM performance mode and routes each read response back to the requester that issued it.
- Sits between the compute/DMA engines and a buffer-RAM port.

Parameters:
- C_NUM_REQ, 4, number of requesters (2..8).
- C_ADDR_WIDTH, 10, RAM port address width.
- C_DATA_WIDTH, 16, RAM port data width.
- C_RD_LATENCY, 1, RAM read latency in clocks: 1 for the low-latency port, 3 for the high-performance port. Any other value is illegal and fails elaboration.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  C_NUM_REQ  per-requester beat valid.
- req_ready  out  C_NUM_REQ  per-requester grant; a beat is accepted when valid&ready.
- req_wr  in  C_NUM_REQ  1 = write beat, 0 = read beat.
- req_last  in  C_NUM_REQ  last beat of the burst; releases the lock.
- req_addr  in  C_NUM_REQ*C_ADDR_WIDTH  packed addresses, requester i at slice i.
- req_wdata  in  C_NUM_REQ*C_DATA_WIDTH  packed write data.
- rsp_valid  out  C_NUM_REQ  one-hot read-data valid.
- rsp_data  out  C_DATA_WIDTH  read data, shared by all requesters.
- ram_addr  out  C_ADDR_WIDTH  to RAM addr.
- ram_wren  out  1  to RAM wren.
- ram_din  out  C_DATA_WIDTH  to RAM din.
- ram_rden  out  1  to RAM rden.
- ram_dout  in  C_DATA_WIDTH  from RAM dout.

Behaviour:
- Reset (async on rst_n low):
  - State = ARB, rr pointer = 0.
  - ram_addr = 0, ram_wren = 0, ram_din = 0, ram_rden = 0.
  - rsp_valid = 0, tag pipeline cleared.
  - req_ready = 0 while in reset.
- ram_rden is held at 1 every cycle out of reset, so the RAM output pipeline advances every clock and the read latency is fixed.
- FSM states: ARB, BURST.
  - ARB: req_ready is one-hot on the first asserted req_valid searching from the rr pointer, wrapping modulo C_NUM_REQ; it is 0 if no request is valid.
    - Accept with req_last=1: stay in ARB, pointer = winner+1 (mod C_NUM_REQ).
    - Accept with req_last=0: go to BURST, owner = winner.
  - BURST: req_ready is asserted only to the owner, gated by the owner's req_valid.
    - Owner dropping req_valid holds the lock; idle cycles are legal and there is no timeout.
    - Accept with req_last=1: go to ARB, pointer = owner+1.
- Issue: on an accepting edge, register ram_addr/ram_din from the winner's slice and set ram_wren = req_wr. On a non-accepting edge, ram_wren = 0 and ram_addr/ram_din hold their values.
- Throughput: one beat per clock, reads and writes freely interleaved, no bubbles between back-to-back beats or between bursts.
- Read tracking: a tag shift register of depth C_RD_LATENCY+1 carries {valid, requester id}, loaded with valid=1 on every accepted read.
  - rsp_valid[id] is asserted exactly C_RD_LATENCY+1 cycles after the acceptance cycle.
  - rsp_data = ram_dout (combinational passthrough).
  - Writes create no response.
- Ordering: responses return in issue order; at most C_RD_LATENCY+1 reads are in flight; there is no backpressure on responses.
- Read-after-write to the same address on consecutive beats returns the new data, because the RAM write completes before the following read samples.
- Reset mid-burst: the lock is dropped, in-flight tags are discarded, and no rsp_valid is produced for pre-reset reads.
- Simultaneous requests in ARB: only the one winner is granted; the others see req_ready=0 and must hold their request.

Decomposition:
- Shared package/header bram_arb_pkg: state encoding (ARB=1'b0, BURST=1'b1), the legal C_RD_LATENCY values, and a tag-width function clog2(C_NUM_REQ) reused from math.vh.
- Sub-module round_robin_arbiter:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; it is reused by other shared-resource controllers.

Test Plan:
- Reset, then release rst_n with no requests -> all outputs 0 except ram_rden = 1 from the first cycle after release; req_ready stays 0.
- C_RD_LATENCY=1: req0 and req1 issue single-beat reads (last=1) to 0x010 and 0x020 in the same cycle, RAM preloaded with 0xAAAA and 0xBBBB -> req0 is granted first and req1 next cycle; rsp_valid=0001 with 0xAAAA two cycles after the first acceptance, then rsp_valid=0010 with 0xBBBB.
- Burst lock: req2 issues a 4-beat write burst to 0x100..0x103 while req0 holds valid the whole time -> req_ready[0]=0 until after req2's last beat, then req0 is granted; RAM contents at 0x100..0x103 are verified.
- C_RD_LATENCY=3: req3 issues back-to-back reads of 0x005..0x008 -> four consecutive rsp_valid[3] pulses beginning 4 cycles after the first acceptance, data in address order.
- RAW: req1 writes 0x1234 to 0x3FF, then reads 0x3FF on the next beat -> the response is 0x1234.
- Reset mid-burst: assert rst_n=0 with 2 reads in flight and req0 locked -> no rsp_valid afterwards; after release, req1 is granted first if it is requesting alone.
